alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
- Multi-cycle sequencer that computes the low 32 bits of a 32x32 product (MULT/MULTU lo) by shift-and-add.
- Performs no addition itself: it drives the shared ALU's aluOp/portA/portB and consumes portOut.
- A req/gnt handshake lets the pipeline keep priority over the shared ALU; the sequencer advances only on granted cycles.
- Two's-complement low word is identical for signed and unsigned operands, so there is no sign handling.

Parameters:
EARLY_EXIT, 0, when 1 the sequencer terminates as soon as the remaining multiplier bits are all zero.

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
start  input  1  begin operation; sampled only in IDLE
abort  input  1  cancel operation in progress
a  input  32  multiplicand (word_t)
b  input  32  multiplier (word_t)
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result valid
result  output  32  product low word; held until the next completed operation
alu_req  output  1  request for the shared ALU this cycle
alu_gnt  input  1  ALU granted this cycle
alu_aluOp  output  aluop_t  ALU opcode
alu_portA  output  32  ALU operand A
alu_portB  output  32  ALU operand B
alu_portOut  input  32  ALU result; combinational response to the current outputs

Behaviour:
- Internal registers: state {IDLE, RUN, DONE}, mcand[31:0], mplier[31:0], acc[31:0], cnt[4:0].
- Reset (async, nRST=0): state=IDLE, acc=0, result=0, cnt=0, busy=0, done=0, alu_req=0.
- Reset mid-operation discards all progress.
- IDLE:
  - On start: mcand<=a, mplier<=b, acc<=0, cnt<=0, state<=RUN.
  - abort is ignored in IDLE; start together with abort is accepted.
- RUN, normal iteration:
  - busy=1, alu_req=1, alu_aluOp=ALU_ADD, alu_portA=acc.
  - alu_portB = mplier[0] ? mcand : 0.
  - On a cycle with alu_gnt=1: acc<=alu_portOut, mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
  - If cnt==31 on that granted cycle: result<=alu_portOut, state<=DONE.
  - alu_gnt=0: all registers hold; request stays asserted.
- RUN with EARLY_EXIT=1 and mplier==0:
  - alu_req=0 that cycle.
  - result<=acc, state<=DONE; takes no grant.
- ALU overflow/zero/negative are ignored; addition wraps mod 2^32.
- DONE: done=1 and busy=0 for exactly one cycle, then state<=IDLE. start is ignored in DONE.
- abort in RUN or DONE: state<=IDLE on the next edge, with abort taking priority over a same-cycle grant.
  - done is not asserted; result keeps its previous value.
  - An abort in the DONE cycle cannot suppress that done pulse, since done is already high; result is already updated.
- Latency with alu_gnt held at 1 and EARLY_EXIT=0:
  - start sampled at edge 0; RUN during cycles 1..32; done high in cycle 33.
  - Each cycle of alu_gnt=0 adds exactly one cycle.
- Whenever alu_req=0: alu_aluOp=ALU_ADD, alu_portA=0, alu_portB=0.
- Grant arbitration is external; the sequencer never assumes a grant in the same cycle it drops req.

Test Plan:
1. Reset, then a=7, b=6, start, gnt tied 1, EARLY_EXIT=0 -> busy for 32 cycles; done pulses in cycle 33; result=0x0000002A; alu_req=0 afterwards.
2. a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0x00000001. Then a=0xFFFFFFFD (-3), b=5 -> result=0xFFFFFFF1.
3. a=7, b=6 with alu_gnt alternating 0/1 -> exactly 64 RUN cycles; registers frozen on gnt=0 cycles; result=0x2A.
4. After test 1, start a=3, b=3, assert abort on RUN cycle 10 -> IDLE next edge; no done; result stays 0x2A. A following start with a=3, b=3 gives result=0x9.
5. EARLY_EXIT=1, a=9, b=2, gnt=1 -> two granted ADDs, then one cycle with alu_req=0; done in cycle 4 after start; result=0x12. b=0 -> done in cycle 2; result=0.
6. Drop nRST mid-RUN at cycle 15 -> busy, done, alu_req and result go to 0 immediately. A start in IDLE during the DONE cycle is ignored, and a start in IDLE together with abort is accepted.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Shift-and-add sequencer for the low 32 bits of a 32x32 product. It never adds by itself.
// Each step borrows the shared ALU through a req/gnt handshake, and the sequencer only advances on granted cycles.

package alu_mul_seq_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_NOR  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } aluop_t;
endpackage

module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int EARLY_EXIT = 0
) (
    input  logic   CLK,
    input  logic   nRST,
    input  logic   start,
    input  logic   abort,
    input  word_t  a,
    input  word_t  b,
    output logic   busy,
    output logic   done,
    output word_t  result,
    output logic   alu_req,
    input  logic   alu_gnt,
    output aluop_t alu_aluOp,
    output word_t  alu_portA,
    output word_t  alu_portB,
    input  word_t  alu_portOut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_r;
    word_t      mcand_r;
    word_t      mplier_r;
    word_t      acc_r;
    word_t      result_r;
    logic [4:0] cnt_r;
    logic       busy_r;
    logic       done_r;
    logic       aluReq_r;
    word_t      mplierNext_s;

    // When early exit is enabled, a zero multiplier means no further partial products remain.
    function automatic logic canStop(input word_t m);
        return (EARLY_EXIT != 0) && (m == 32'd0);
    endfunction

    function automatic word_t addend(input word_t m, input logic sel);
        return sel ? m : 32'd0;
    endfunction

    assign mplierNext_s = {1'b0, mplier_r[31:1]};

    // Sequencer FSM. The request for the next cycle is computed here, so alu_req comes straight from a flop.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r  <= IDLE;
            mcand_r  <= 32'd0;
            mplier_r <= 32'd0;
            acc_r    <= 32'd0;
            result_r <= 32'd0;
            cnt_r    <= 5'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            aluReq_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        mcand_r  <= a;
                        mplier_r <= b;
                        acc_r    <= 32'd0;
                        cnt_r    <= 5'd0;
                        state_r  <= RUN;
                        busy_r   <= 1'b1;
                        aluReq_r <= !canStop(b);
                    end else begin
                        busy_r   <= 1'b0;
                        aluReq_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_r  <= IDLE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b0;
                        aluReq_r <= 1'b0;
                    end else if (canStop(mplier_r)) begin
                        result_r <= acc_r;
                        state_r  <= DONE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        aluReq_r <= 1'b0;
                    end else if (alu_gnt) begin
                        acc_r    <= alu_portOut;
                        mcand_r  <= {mcand_r[30:0], 1'b0};
                        mplier_r <= mplierNext_s;
                        cnt_r    <= cnt_r + 5'd1;
                        if (cnt_r == 5'd31) begin
                            result_r <= alu_portOut;
                            state_r  <= DONE;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                            aluReq_r <= 1'b0;
                        end else begin
                            aluReq_r <= !canStop(mplierNext_s);
                        end
                    end else begin
                        aluReq_r <= 1'b1;
                    end
                end
                DONE: begin
                    state_r  <= IDLE;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                    aluReq_r <= 1'b0;
                end
                default: begin
                    state_r  <= IDLE;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                    aluReq_r <= 1'b0;
                end
            endcase
        end
    end

    // The ALU operand buses are forced to zero whenever the ALU is not requested.
    assign alu_portA = aluReq_r ? acc_r : 32'd0;
    assign alu_portB = aluReq_r ? addend(mcand_r, mplier_r[0]) : 32'd0;
    assign alu_aluOp = ALU_ADD;
    assign alu_req   = aluReq_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq. It runs an EARLY_EXIT=0 and an EARLY_EXIT=1 instance side by side on shared stimulus.
// Each instance is backed by its own behavioural ALU.

module tb_alu_mul_seq;
    import alu_mul_seq_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST = 1'b0;
    logic  start = 1'b0;
    logic  abort = 1'b0;
    logic  gnt = 1'b0;
    word_t a = 32'd0;
    word_t b = 32'd0;
    logic  useEe = 1'b0;

    logic   busy0, done0, req0, busy1, done1, req1;
    word_t  res0, pA0, pB0, pO0, res1, pA1, pB1, pO1;
    aluop_t op0, op1;

    logic   busyS, doneS, reqS;
    word_t  resS, pAS, pBS;
    aluop_t opS;

    int nTests = 0;
    int nFail = 0;

    always #5 CLK = ~CLK;

    // The ALU model gives a wrong answer for any opcode other than ADD.
    assign pO0 = (op0 == ALU_ADD) ? pA0 + pB0 : pA0 ^ pB0;
    assign pO1 = (op1 == ALU_ADD) ? pA1 + pB1 : pA1 ^ pB1;

    assign busyS = useEe ? busy1 : busy0;
    assign doneS = useEe ? done1 : done0;
    assign reqS  = useEe ? req1  : req0;
    assign resS  = useEe ? res1  : res0;
    assign pAS   = useEe ? pA1   : pA0;
    assign pBS   = useEe ? pB1   : pB0;
    assign opS   = useEe ? op1   : op0;

    alu_mul_seq #(.EARLY_EXIT(0)) dut0 (
        .CLK(CLK), .nRST(nRST), .start(start), .abort(abort), .a(a), .b(b),
        .busy(busy0), .done(done0), .result(res0), .alu_req(req0), .alu_gnt(gnt),
        .alu_aluOp(op0), .alu_portA(pA0), .alu_portB(pB0), .alu_portOut(pO0)
    );

    alu_mul_seq #(.EARLY_EXIT(1)) dut1 (
        .CLK(CLK), .nRST(nRST), .start(start), .abort(abort), .a(a), .b(b),
        .busy(busy1), .done(done1), .result(res1), .alu_req(req1), .alu_gnt(gnt),
        .alu_aluOp(op1), .alu_portA(pA1), .alu_portB(pB1), .alu_portOut(pO1)
    );

    typedef struct {
        word_t a;
        word_t b;
        bit    ee;
        bit    alt;
        int    doneCyc;
        int    runCyc;
        int    reqCyc;
        word_t res;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic startOp(input word_t av, input word_t bv, input logic abt);
        a = av;
        b = bv;
        start = 1'b1;
        abort = abt;
        gnt = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Observes the selected instance from RUN cycle 1 up to its done cycle. On return the bench is still inside the done cycle.
    task automatic watch(input bit alt, input word_t prevRes, output int doneCyc,
                         output int runCyc, output int reqCyc, output int viol);
        logic  prevGnt;
        word_t prevA, prevB;
        doneCyc = -1;
        runCyc = 0;
        reqCyc = 0;
        viol = 0;
        prevGnt = 1'b1;
        prevA = 32'd0;
        prevB = 32'd0;
        for (int c = 1; c <= 200; c++) begin
            if (doneS) begin
                doneCyc = c;
                break;
            end
            if (busyS) runCyc++;
            if (reqS) reqCyc++;
            if (!reqS && (pAS !== 32'd0 || pBS !== 32'd0)) viol++;
            if (opS !== ALU_ADD) viol++;
            if (busyS && resS !== prevRes) viol++;
            if (c > 1 && !prevGnt && busyS && (pAS !== prevA || pBS !== prevB)) viol++;
            prevA = pAS;
            prevB = pBS;
            gnt = alt ? ((c % 2) == 0) : 1'b1;
            prevGnt = gnt;
            tick();
        end
    endtask

    task automatic settle();
        int n;
        n = 0;
        gnt = 1'b1;
        while ((busy0 || busy1 || done0 || done1) && n < 200) begin
            tick();
            n++;
        end
        chk("settle_timeout", (n < 200) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Starts a plain (grant always 1) operation and checks its latency and result.
    task automatic fullOp(input string name, input word_t av, input word_t bv, input logic abt,
                          input word_t expRes);
        int dc, rc, qc, vl;
        word_t prevRes;
        prevRes = resS;
        startOp(av, bv, abt);
        watch(1'b0, prevRes, dc, rc, qc, vl);
        chk({name, "_donecyc"}, dc, 33);
        chk({name, "_result"}, resS, expRes);
        chk({name, "_viol"}, vl, 0);
    endtask

    initial begin
        int dc, rc, qc, vl, pulses;
        word_t prevRes;

        vecs[0] = '{32'd7,          32'd6,          1'b0, 1'b0, 33, 32, 32, 32'h0000002A};
        vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 1'b0, 33, 32, 32, 32'h00000001};
        vecs[2] = '{32'hFFFFFFFD,   32'd5,          1'b0, 1'b0, 33, 32, 32, 32'hFFFFFFF1};
        vecs[3] = '{32'd7,          32'd6,          1'b0, 1'b1, 65, 64, 64, 32'h0000002A};
        vecs[4] = '{32'd9,          32'd2,          1'b1, 1'b0, 4,  3,  2,  32'h00000012};
        vecs[5] = '{32'd9,          32'd0,          1'b1, 1'b0, 2,  1,  0,  32'h00000000};
        vecs[6] = '{32'd5,          32'h80000000,   1'b1, 1'b0, 33, 32, 32, 32'h80000000};
        vecs[7] = '{32'h12345678,   32'h00000010,   1'b1, 1'b0, 7,  6,  5,  32'h23456780};
        vecs[8] = '{32'h12345678,   32'h00000010,   1'b0, 1'b0, 33, 32, 32, 32'h23456780};
        vecs[9] = '{32'hABCD1234,   32'd0,          1'b0, 1'b0, 33, 32, 32, 32'h00000000};

        // Reset state
        #12;
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_req", req0, 1'b0);
        chk("rst_result", res0, 32'd0);
        chk("rst_portA", pA0, 32'd0);
        chk("rst_result_ee", res1, 32'd0);
        nRST = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            useEe = vecs[i].ee;
            prevRes = resS;
            startOp(vecs[i].a, vecs[i].b, 1'b0);
            watch(vecs[i].alt, prevRes, dc, rc, qc, vl);
            chk($sformatf("v%0d_donecyc", i), dc, vecs[i].doneCyc);
            chk($sformatf("v%0d_runcyc", i), rc, vecs[i].runCyc);
            chk($sformatf("v%0d_reqcyc", i), qc, vecs[i].reqCyc);
            chk($sformatf("v%0d_result", i), resS, vecs[i].res);
            chk($sformatf("v%0d_busy_at_done", i), busyS, 1'b0);
            chk($sformatf("v%0d_viol", i), vl, 0);
            tick();
            chk($sformatf("v%0d_done_pulse", i), doneS, 1'b0);
            chk($sformatf("v%0d_req_after", i), reqS, 1'b0);
            chk($sformatf("v%0d_result_held", i), resS, vecs[i].res);
            settle();
        end

        // Abort in RUN cycle 10 while the grant is high. The abort must win, and result must keep its earlier value.
        useEe = 1'b0;
        fullOp("pre_abort", 32'd7, 32'd6, 1'b0, 32'h2A);
        tick();
        settle();
        startOp(32'd3, 32'd3, 1'b0);
        repeat (9) tick();
        chk("abort_busy_before", busy0, 1'b1);
        abort = 1'b1;
        gnt = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy0, 1'b0);
        chk("abort_req", req0, 1'b0);
        chk("abort_done", done0, 1'b0);
        chk("abort_result", res0, 32'h2A);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (done0) pulses++;
            tick();
        end
        chk("abort_no_done", pulses, 0);
        chk("abort_result_kept", res0, 32'h2A);
        settle();
        fullOp("after_abort", 32'd3, 32'd3, 1'b0, 32'h9);
        tick();
        settle();

        // Asynchronous reset in RUN cycle 15
        startOp(32'd7, 32'd6, 1'b0);
        repeat (14) tick();
        chk("mrst_busy_before", busy0, 1'b1);
        nRST = 1'b0;
        #1;
        chk("mrst_busy", busy0, 1'b0);
        chk("mrst_done", done0, 1'b0);
        chk("mrst_req", req0, 1'b0);
        chk("mrst_result", res0, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        chk("mrst_idle", busy0, 1'b0);

        // A start raised during the DONE cycle must be ignored
        fullOp("done_start", 32'd2, 32'd3, 1'b0, 32'h6);
        a = 32'd8;
        b = 32'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_start_ignored", busy0, 1'b0);
        chk("done_start_req", req0, 1'b0);
        tick();
        chk("done_start_still_idle", busy0, 1'b0);
        settle();

        // In IDLE, start together with abort must be accepted
        prevRes = res0;
        startOp(32'd4, 32'd5, 1'b1);
        chk("start_abort_busy", busy0, 1'b1);
        watch(1'b0, prevRes, dc, rc, qc, vl);
        chk("start_abort_donecyc", dc, 33);
        chk("start_abort_result", res0, 32'h14);
        tick();
        settle();

        // An abort in the DONE cycle leaves that done pulse and the new result unchanged
        fullOp("done_abort", 32'd6, 32'd7, 1'b0, 32'h2A);
        chk("done_abort_pulse", done0, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("done_abort_done_low", done0, 1'b0);
        chk("done_abort_busy", busy0, 1'b0);
        chk("done_abort_result", res0, 32'h2A);
        tick();
        chk("done_abort_idle", busy0, 1'b0);
        settle();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
